// File: rtl/isa_mon_pkg.sv
// +--------------------------------------------------------------------------+
// | isa_mon_pkg : shared types for the ISA-test console monitor   Rev 1.0    |
// +--------------------------------------------------------------------------+
`default_nettype none

package isa_mon_pkg;

  localparam int c_pc_w = 32;

  typedef enum logic [1:0] {
    MON_IDLE    = 2'd0,
    MON_RUN     = 2'd1,
    MON_DONE    = 2'd2,
    MON_TIMEOUT = 2'd3
  } mon_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// +--------------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO with registered storage         Rev 1.0    |
// +--------------------------------------------------------------------------+
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int c_aw = $clog2(DEPTH);

  logic [c_aw:0]      r_wr_ptr;
  logic [c_aw:0]      r_rd_ptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic               w_do_push;
  logic               w_do_pop;

  // The extra pointer MSB separates full (MSBs differ) from empty (all equal).
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/isa_test_monitor.sv
// +--------------------------------------------------------------------------+
// | isa_test_monitor : PC-triggered console capture, end/timeout flags Rev 1.0|
// +--------------------------------------------------------------------------+
`default_nettype none

module isa_test_monitor
  import isa_mon_pkg::*;
#(
  parameter logic [31:0] PRINT_PC    = 32'h14,
  parameter logic [31:0] END_PC      = 32'h1C,
  parameter int          CHAR_W      = 8,
  parameter int          FIFO_DEPTH  = 16,
  parameter int          TIMEOUT_CYC = 1_000_000,
  parameter int          CNT_W       = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [31:0]       o_pc_debug,
  input  logic [31:0]       o_io_ledr,
  output logic [CHAR_W-1:0] o_char,
  output logic              o_char_valid,
  input  logic              i_char_ready,
  output logic              o_done,
  output logic              o_timeout,
  output logic              o_overflow,
  output logic [CNT_W-1:0]  o_cycle_count,
  output logic [CNT_W-1:0]  o_char_count
);

  localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYC - 1);

  mon_state_e         r_state;
  logic               r_done;
  logic               r_timeout;
  logic               r_overflow;
  logic [CNT_W-1:0]   r_cycle_count;
  logic [CNT_W-1:0]   r_char_count;

  logic               w_in_run;
  logic               w_end_hit;
  logic               w_wd_expire;
  logic               w_push_req;
  logic               w_pop;
  logic               w_accept;
  logic               w_full;
  logic               w_empty;

  assign w_in_run    = (r_state == MON_RUN);
  assign w_end_hit   = (o_pc_debug == END_PC);
  assign w_wd_expire = (TIMEOUT_CYC != 0) && (r_cycle_count == c_timeout_last);
  assign w_push_req  = w_in_run && (o_pc_debug == PRINT_PC);
  assign w_pop       = !w_empty && i_char_ready;
  // A full FIFO still takes a character when the sink frees a slot this cycle.
  assign w_accept    = w_push_req && (!w_full || w_pop);

  sync_fifo #(
    .WIDTH (CHAR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_accept),
    .i_data  (o_io_ledr[CHAR_W-1:0]),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (o_char)
  );

  generate
    if (CHAR_W < 32) begin : g_ledr_unused
      logic w_unused_ledr;
      assign w_unused_ledr = ^o_io_ledr[31:CHAR_W];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= MON_IDLE;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
      r_overflow    <= 1'b0;
      r_cycle_count <= '0;
      r_char_count  <= '0;
    end else begin
      case (r_state)
        MON_IDLE: begin
          if (i_enable) r_state <= MON_RUN;
        end
        MON_RUN: begin
          if (r_cycle_count != '1) r_cycle_count <= r_cycle_count + 1'b1;
          // End of test wins over a watchdog expiring on the same cycle.
          if (w_end_hit) begin
            r_state <= MON_DONE;
            r_done  <= 1'b1;
          end else if (w_wd_expire) begin
            r_state   <= MON_TIMEOUT;
            r_timeout <= 1'b1;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
      if (w_accept && (r_char_count != '1)) r_char_count <= r_char_count + 1'b1;
      if (w_push_req && !w_accept)          r_overflow   <= 1'b1;
    end
  end

  assign o_char_valid  = !w_empty;
  assign o_done        = r_done;
  assign o_timeout     = r_timeout;
  assign o_overflow    = r_overflow;
  assign o_cycle_count = r_cycle_count;
  assign o_char_count  = r_char_count;

endmodule

`default_nettype wire
